// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port ROM among NREQ read requesters.
// A {valid, id} tag pipeline follows each read so its data returns to the issuer.
module rom_read_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_dout,
  output logic                   busy
);

  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = ROM_LAT + 2;
  localparam int LAST  = DEPTH - 1;

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    grantId;
  logic              grantAny;
  logic [IDW:0]      cand;
  logic [ADDR_W-1:0] grantAddr;
  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  logic [DEPTH-1:0]  tagValid_q, tagValid_d;
  logic [IDW-1:0]    tagId_q [DEPTH];
  logic [IDW-1:0]    tagId_d [DEPTH];
  logic [DATA_W-1:0] rspData_q, rspData_d;

  // Search pointer, pointer+1, ... wrapping at NREQ; the first valid requester wins.
  always_comb begin
    grantAny = 1'b0;
    grantId  = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grantAny && req_valid[cand[IDW-1:0]]) begin
        grantAny = 1'b1;
        grantId  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grantAddr = req_addr[grantId*ADDR_W +: ADDR_W];
    req_ready = grantAny ? (NREQ'(1) << grantId) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grantAny) begin
      ptr_d = (grantId == IDW'(NREQ - 1)) ? '0 : grantId + IDW'(1);
    end
  end

  // Stage 0 lines up with rom_addr; stage ROM_LAT lines up with valid rom_dout.
  always_comb begin
    tagValid_d = {tagValid_q[DEPTH-2:0], grantAny};
    tagId_d[0] = grantId;
    for (int s = 1; s < DEPTH; s++) begin
      tagId_d[s] = tagId_q[s-1];
    end
    romAddr_d = grantAny ? grantAddr : romAddr_q;
    rspData_d = tagValid_q[ROM_LAT] ? rom_dout : rspData_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      romAddr_q  <= '0;
      tagValid_q <= '0;
      rspData_q  <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        tagId_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      romAddr_q  <= romAddr_d;
      tagValid_q <= tagValid_d;
      rspData_q  <= rspData_d;
      for (int s = 0; s < DEPTH; s++) begin
        tagId_q[s] <= tagId_d[s];
      end
    end
  end

  always_comb begin
    rom_addr  = romAddr_q;
    rsp_data  = rspData_q;
    rsp_valid = tagValid_q[LAST] ? (NREQ'(1) << tagId_q[LAST]) : '0;
    busy      = |tagValid_q;
  end

  // Grants and responses are each at most one-hot.
  assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));
  assert property (@(posedge clock) disable iff (reset) $onehot0(rsp_valid));

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed vector table, streaming and
// reset corners, randomized traffic against a queue model, and an NREQ=3/ROM_LAT=2 sweep.
module tb_rom_read_arbiter;

  localparam int AW = 18;
  localparam int DW = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]      reqValidA = '0;
  logic [2*AW-1:0] reqAddrA  = '0;
  logic [1:0]      reqReadyA, rspValidA;
  logic [DW-1:0]   rspDataA, romDoutA;
  logic [AW-1:0]   romAddrA;
  logic            busyA;

  logic [2:0]      reqValidB = '0;
  logic [3*AW-1:0] reqAddrB  = '0;
  logic [2:0]      reqReadyB, rspValidB;
  logic [DW-1:0]   rspDataB, romDoutB, romPipeB;
  logic [AW-1:0]   romAddrB;
  logic            busyB;

  rom_read_arbiter #(.NREQ(2), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dutA (
    .clock(clock), .reset(reset), .req_valid(reqValidA), .req_addr(reqAddrA),
    .req_ready(reqReadyA), .rsp_valid(rspValidA), .rsp_data(rspDataA),
    .rom_addr(romAddrA), .rom_dout(romDoutA), .busy(busyA));

  rom_read_arbiter #(.NREQ(3), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dutB (
    .clock(clock), .reset(reset), .req_valid(reqValidB), .req_addr(reqAddrB),
    .req_ready(reqReadyB), .rsp_valid(rspValidB), .rsp_data(rspDataB),
    .rom_addr(romAddrB), .rom_dout(romDoutB), .busy(busyB));

  function automatic logic [DW-1:0] romData(input logic [AW-1:0] a);
    return {a[5:0], a} ^ 24'h5A3C96;
  endfunction

  // ROM stand-ins with one and two cycles of read latency.
  always @(posedge clock) romDoutA <= romData(romAddrA);
  always @(posedge clock) begin
    romPipeB <= romData(romAddrB);
    romDoutB <= romPipeB;
  end

  int checksTotal  = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    valid;
    logic [AW-1:0] a0, a1;
    logic [1:0]    expReady;
    logic [AW-1:0] expRomAddr;
    logic [1:0]    expRsp;
    logic [AW-1:0] expRspAddr;
    logic          expBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic [1:0] valid, input logic [AW-1:0] a0, a1,
                        input logic [1:0] rdy, input logic [AW-1:0] ra, input logic [1:0] rsp,
                        input logic [AW-1:0] rspA, input logic bsy);
    vec_t v;
    v = '{rst, valid, a0, a1, rdy, ra, rsp, rspA, bsy};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    reset     = v.rst;
    reqValidA = v.valid;
    reqAddrA  = {v.a1, v.a0};
    @(negedge clock);
    checkOutput($sformatf("vec%0d ready", idx), reqReadyA, v.expReady);
    checkOutput($sformatf("vec%0d rom_addr", idx), romAddrA, v.expRomAddr);
    checkOutput($sformatf("vec%0d rsp_valid", idx), rspValidA, v.expRsp);
    if (v.expRsp != 0) checkOutput($sformatf("vec%0d rsp_data", idx), rspDataA, romData(v.expRspAddr));
    checkOutput($sformatf("vec%0d busy", idx), busyA, v.expBusy);
    @(posedge clock); #1;
  endtask

  function automatic int rrPick(input logic [7:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;

  task automatic pulseReset();
    reqValidA = '0;
    reqValidB = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    rsp_t          q[$];
    rsp_t          head;
    int            ptrM, g;
    int            served[3];
    logic [AW-1:0] romAddrM;
    logic [1:0]    lastGrant;
    logic [31:0]   expRsp, expReady;

    // Single read, alternating pair, early drop, reset mid-flight
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 'h10, 0, 1, 0, 0, 0, 0);
    addVec(0, 0, 'h10, 0, 0, 'h10, 0, 0, 1);
    addVec(0, 0, 'h10, 0, 0, 'h10, 0, 0, 1);
    addVec(0, 0, 'h10, 0, 0, 'h10, 1, 'h10, 1);
    addVec(0, 0, 'h10, 0, 0, 'h10, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 3, 'h100, 'h200, 1, 0, 0, 0, 0);
    addVec(0, 3, 'h100, 'h200, 2, 'h100, 0, 0, 1);
    addVec(0, 3, 'h100, 'h200, 1, 'h200, 0, 0, 1);
    addVec(0, 3, 'h100, 'h200, 2, 'h100, 1, 'h100, 1);
    addVec(0, 3, 'h100, 'h200, 1, 'h200, 2, 'h200, 1);
    addVec(0, 3, 'h100, 'h200, 2, 'h100, 1, 'h100, 1);
    addVec(0, 0, 'h100, 'h200, 0, 'h200, 2, 'h200, 1);
    addVec(0, 0, 'h100, 'h200, 0, 'h200, 1, 'h100, 1);
    addVec(0, 0, 'h100, 'h200, 0, 'h200, 2, 'h200, 1);
    addVec(0, 0, 'h100, 'h200, 0, 'h200, 0, 0, 0);
    addVec(0, 3, 'h30, 'h40, 1, 'h200, 0, 0, 0);
    addVec(0, 0, 'h30, 'h40, 0, 'h30, 0, 0, 1);
    addVec(0, 3, 'h30, 'h40, 2, 'h30, 0, 0, 1);
    addVec(0, 1, 'h30, 'h40, 1, 'h40, 1, 'h30, 1);
    addVec(0, 0, 'h30, 'h40, 0, 'h30, 0, 0, 1);
    addVec(0, 0, 'h30, 'h40, 0, 'h30, 2, 'h40, 1);
    addVec(0, 0, 'h30, 'h40, 0, 'h30, 1, 'h30, 1);
    addVec(0, 0, 'h30, 'h40, 0, 'h30, 0, 0, 0);
    addVec(0, 3, 'h50, 'h60, 2, 'h30, 0, 0, 0);
    addVec(0, 3, 'h50, 'h60, 1, 'h60, 0, 0, 1);
    addVec(1, 0, 'h50, 'h60, 0, 0, 0, 0, 0);
    addVec(0, 0, 'h50, 'h60, 0, 0, 0, 0, 0);
    addVec(0, 0, 'h50, 'h60, 0, 0, 0, 0, 0);
    addVec(0, 3, 'h50, 'h60, 1, 0, 0, 0, 0);
    addVec(0, 0, 'h50, 'h60, 0, 'h50, 0, 0, 1);
    addVec(0, 0, 'h50, 'h60, 0, 'h50, 0, 0, 1);
    addVec(0, 0, 'h50, 'h60, 0, 'h50, 1, 'h50, 1);
    addVec(0, 0, 'h50, 'h60, 0, 'h50, 0, 0, 0);

    @(posedge clock); #1;
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);
    reset = 1'b0;

    // Requester 0 streams addresses 0..15 back to back
    pulseReset();
    for (int c = 0; c < 20; c++) begin
      reqValidA = (c < 16) ? 2'b01 : 2'b00;
      reqAddrA  = {AW'($urandom), AW'(c)};
      @(negedge clock);
      checkOutput($sformatf("stream%0d ready", c), reqReadyA, (c < 16) ? 1 : 0);
      checkOutput($sformatf("stream%0d rsp_valid", c), rspValidA, (c >= 3 && c < 19) ? 1 : 0);
      if (c >= 3 && c < 19) checkOutput($sformatf("stream%0d rsp_data", c), rspDataA, romData(AW'(c - 3)));
      @(posedge clock); #1;
    end

    // Randomized traffic against an issue-order queue model
    pulseReset();
    ptrM = 0;
    romAddrM = '0;
    lastGrant = '0;
    for (int c = 0; c < 405; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (c >= 400) reqValidA[i] = 1'b0;
        else if (!(reqValidA[i] && !lastGrant[i] && $urandom_range(0, 3) != 0)) begin
          reqValidA[i] = ($urandom_range(0, 2) != 0);
          reqAddrA[i*AW +: AW] = AW'($urandom);
        end
      end
      @(negedge clock);
      checkOutput($sformatf("rand%0d busy", c), busyA, (q.size() != 0) ? 1 : 0);
      expRsp = 0;
      if (q.size() != 0 && q[0].due == c) begin
        head = q.pop_front();
        expRsp = 1 << head.id;
        checkOutput($sformatf("rand%0d rsp_data", c), rspDataA, head.data);
      end
      checkOutput($sformatf("rand%0d rsp_valid", c), rspValidA, expRsp);
      checkOutput($sformatf("rand%0d rom_addr", c), romAddrA, romAddrM);
      g = rrPick(8'(reqValidA), ptrM, 2);
      expReady = (g >= 0) ? (1 << g) : 0;
      checkOutput($sformatf("rand%0d ready", c), reqReadyA, expReady);
      lastGrant = expReady[1:0];
      if (g >= 0) begin
        q.push_back('{c + 3, g, romData(reqAddrA[g*AW +: AW])});
        romAddrM = reqAddrA[g*AW +: AW];
        ptrM = (g + 1) % 2;
      end
      @(posedge clock); #1;
    end
    checkOutput("rand drained", q.size(), 0);

    // Three requesters, two-cycle ROM, all always valid
    pulseReset();
    reqValidB = 3'b111;
    reqAddrB  = {18'h333, 18'h222, 18'h111};
    served = '{0, 0, 0};
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      checkOutput($sformatf("sweep%0d ready", c), reqReadyB, 1 << (c % 3));
      checkOutput($sformatf("sweep%0d busy", c), busyB, (c >= 1) ? 1 : 0);
      if (c >= 1) checkOutput($sformatf("sweep%0d rom_addr", c), romAddrB, reqAddrB[((c - 1) % 3)*AW +: AW]);
      if (c >= 4) begin
        checkOutput($sformatf("sweep%0d rsp_valid", c), rspValidB, 1 << ((c - 4) % 3));
        checkOutput($sformatf("sweep%0d rsp_data", c), rspDataB, romData(reqAddrB[((c - 4) % 3)*AW +: AW]));
      end else begin
        checkOutput($sformatf("sweep%0d rsp_valid", c), rspValidB, 0);
      end
      if (c >= 4 && c <= 12) begin
        for (int i = 0; i < 3; i++) if (rspValidB[i]) served[i]++;
      end
      @(posedge clock); #1;
    end
    for (int i = 0; i < 3; i++) checkOutput($sformatf("sweep served%0d", i), served[i], 3);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
